// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction-memory read bus used by the fetch unit.
// The master (fetch unit) offers req/addr. The slave (memory) answers with gnt
// in the same cycle and later returns dv/data, one response per accepted
// request, in issue order.
interface inst_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            dv;
  logic [XLEN-1:0] data;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  dv,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output dv,
    output data
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage feeding the decoder.
// - Generates the sequential PC stream and issues word reads over mem (req/gnt, dv).
// - Keeps the PC of every request in an in-order tag queue. Each returned word is
//   paired with its PC and buffered in a small FIFO.
// - Presents the FIFO head as inst/cur_pc/inst_dv.
// - flush_pipe redirects to br_addr. Buffered words are dropped, and responses
//   still in flight at that moment are counted and discarded on arrival.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_cnt/drop_cnt event
// counter outputs.
//
// Handshake semantics:
//   mem.req/mem.addr is an offer. A read is issued on a cycle with req && gnt.
//   An ungranted offer stays unchanged on the next cycle, unless flush_pipe
//   withdraws it. mem.dv has no backpressure: each issued read returns exactly
//   one dv, in issue order. Toward the decoder, an instruction is consumed on a
//   cycle with inst_dv && !stall.
module inst_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4,
  parameter int              MAX_OUTSTD = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_pipe,
  input  logic [XLEN-1:0]     br_addr,
  input  logic                stall,
  inst_fetch_unit_if.master   mem,
  output logic [XLEN-1:0]     inst,
  output logic [XLEN-1:0]     cur_pc,
  output logic                inst_dv,
  output logic [1:0]          dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetch_cnt,
  output logic [31:0]         drop_cnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int OW  = $clog2(MAX_OUTSTD + 1);
  localparam int TW  = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [OW-1:0]   outstd_q;
  logic [OW-1:0]   outstd_nxt;
  logic [OW-1:0]   discard_q;

  logic [XLEN-1:0] fifo_inst [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc   [FIFO_DEPTH];
  logic [FAW-1:0]  wr_ptr, rd_ptr;
  logic [FCW-1:0]  count_q, count_nxt;

  logic [XLEN-1:0] tag_pc [MAX_OUTSTD];
  logic [TW-1:0]   tag_wr, tag_rd;

  logic issue;
  logic resp;
  logic discard;
  logic push;
  logic pop;
  logic at_limit;

  // The tag queue depth need not be a power of two, so wrap explicitly.
  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    if (int'(p) == MAX_OUTSTD - 1) return '0;
    return p + TW'(1);
  endfunction

  // Request offer: only while fetching. A flush withdraws it for that cycle.
  assign mem.req  = (state_q == S_FETCH) && !flush_pipe;
  assign mem.addr = pc_q;

  // Memory events. A dv with nothing outstanding is ignored.
  // During a flush, every response is stale.
  assign issue   = mem.req && mem.gnt;
  assign resp    = mem.dv && (outstd_q != '0);
  assign discard = resp && (flush_pipe || (discard_q != '0));
  assign push    = resp && !discard;

  // Decoder side: show the FIFO head unless this cycle is being flushed.
  assign inst_dv   = (count_q != '0) && !flush_pipe;
  assign pop       = inst_dv && !stall;
  assign inst      = fifo_inst[rd_ptr];
  assign cur_pc    = fifo_pc[rd_ptr];
  assign dbg_state = state_q;

  // Next-cycle occupancy. This drives the credit decision, so an S_FETCH
  // state always has room for one more request.
  always_comb begin
    outstd_nxt = outstd_q + OW'(issue) - OW'(resp);
    count_nxt  = count_q;
    if (flush_pipe) count_nxt = '0;
    else            count_nxt = count_q + FCW'(push) - FCW'(pop);
    at_limit   = (int'(outstd_nxt) + int'(count_nxt) >= FIFO_DEPTH) ||
                 (int'(outstd_nxt) >= MAX_OUTSTD);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_BOOT;
    else     state_q <= state_d;
  end

  // FSM next state. A flush restarts fetching, but it still respects credit:
  // when the dropped reads already use every slot, wait in S_FULL until they
  // drain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (at_limit)  state_d = S_FULL;
      S_FULL:  if (!at_limit) state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase
    if (flush_pipe) state_d = at_limit ? S_FULL : S_FETCH;
  end

  // PC, outstanding-read count and pending-discard count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      outstd_q  <= '0;
      discard_q <= '0;
    end else begin
      outstd_q <= outstd_nxt;
      if (flush_pipe) begin
        pc_q      <= br_addr & ALIGN_MASK;
        discard_q <= outstd_nxt;
      end else begin
        if (issue) pc_q <= pc_q + XLEN'(4);
        if (resp && (discard_q != '0)) discard_q <= discard_q - OW'(1);
      end
    end
  end

  // Tag queue pointers. A flush empties the queue, because all in-flight
  // entries become stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else if (flush_pipe) begin
      tag_wr <= '0;
      tag_rd <= '0;
    end else begin
      if (issue) tag_wr <= tag_next(tag_wr);
      if (push)  tag_rd <= tag_next(tag_rd);
    end
  end

  // Tag queue storage: the PC of each issued request.
  always_ff @(posedge clk) begin
    if (issue) tag_pc[tag_wr] <= pc_q;
  end

  // Instruction/PC FIFO. Storage is cleared on reset, so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      count_q <= count_nxt;
      if (flush_pipe) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          fifo_inst[wr_ptr] <= mem.data;
          fifo_pc[wr_ptr]   <= tag_pc[tag_rd];
          wr_ptr            <= wr_ptr + FAW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + FAW'(1);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Event counters: words accepted into the FIFO and responses thrown away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (push)    fetch_cnt <= fetch_cnt + 32'd1;
      if (discard) drop_cnt  <= drop_cnt + 32'd1;
    end
  end
`endif

  // The memory must never return data when no read is outstanding.
  dv_needs_outstanding: assert property (
    @(posedge clk) disable iff (rst) !(mem.dv && (outstd_q == '0)));

endmodule
